// File: rtl/shift_add_multiplier.sv
// Sequential 4x4 unsigned shift-and-add multiplier with a start/ready/done handshake.
// The per-iteration add runs on a gate-level ripple-carry four_bit_full_adder.

module four_bit_full_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [4:0] carry_s;

    assign carry_s[0] = cin;

    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign sum[i]       = a[i] ^ b[i] ^ carry_s[i];
        assign carry_s[i+1] = (a[i] & b[i]) | (carry_s[i] & (a[i] ^ b[i]));
    end

    assign cout = carry_s[4];
endmodule

module shift_add_multiplier #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 ready,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;
    logic [1:0]         cnt_q, cnt_d;
    logic [2*WIDTH-1:0] product_q, product_d;

    logic [WIDTH-1:0]   addend_s;
    logic [WIDTH-1:0]   sum_s;
    logic               cout_s;

    assign addend_s = acc_lo_q[0] ? mcand_q : 4'h0;

    four_bit_full_adder u_adder (
        .a    (acc_hi_q),
        .b    (addend_s),
        .cin  (1'b0),
        .sum  (sum_s),
        .cout (cout_s)
    );

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            mcand_q   <= 4'h0;
            acc_hi_q  <= 4'h0;
            acc_lo_q  <= 4'h0;
            cnt_q     <= 2'd0;
            product_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    // Next-state logic; an unused encoding falls back to idle
    always_comb begin
        state_d = ST_IDLE;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_RUN;
                else       state_d = ST_IDLE;
            end
            ST_RUN: begin
                if (cnt_q == 2'd3) state_d = ST_DONE;
                else               state_d = ST_RUN;
            end
            ST_DONE: begin
                if (start) state_d = ST_RUN;
                else       state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath next values: operand load on accept, one shift-add per RUN cycle
    always_comb begin
        mcand_d   = mcand_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    mcand_d  = a;
                    acc_lo_d = b;
                    acc_hi_d = 4'h0;
                    cnt_d    = 2'd0;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_RUN: begin
                // 9-bit {cout,sum,acc_lo} shifted right by one keeps the adder carry
                acc_hi_d = {cout_s, sum_s[WIDTH-1:1]};
                acc_lo_d = {sum_s[0], acc_lo_q[WIDTH-1:1]};
                cnt_d    = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    product_d = {cout_s, sum_s, acc_lo_q[WIDTH-1:1]};
                end else begin
                    product_d = product_q;
                end
            end
            default: begin
                cnt_d = 2'd0;
            end
        endcase
    end

    // Handshake outputs decoded from the registered state only
    always_comb begin
        ready = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
        case (state_q)
            ST_IDLE: ready = 1'b1;
            ST_RUN:  busy  = 1'b1;
            ST_DONE: begin
                ready = 1'b1;
                done  = 1'b1;
            end
            default: begin
                ready = 1'b0;
                busy  = 1'b0;
                done  = 1'b0;
            end
        endcase
    end

    assign product = product_q;
endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier: vector table, handshake corner cases,
// random and exhaustive operands checked against plain a*b.

module tb_shift_add_multiplier;
    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic       ready;
    logic       busy;
    logic       done;
    logic [7:0] product;

    int checks;
    int errors;

    typedef struct {
        logic [3:0] va;
        logic [3:0] vb;
        logic [7:0] exp_p;
    } vec_t;

    vec_t vecs[8];

    shift_add_multiplier #(.WIDTH(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .ready   (ready),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full operation: pulse start, count busy cycles, check done pulse and product
    task automatic run_op(input logic [3:0] ia, input logic [3:0] ib, input string name);
        int busy_cnt;
        int guard;
        logic [7:0] prev;
        logic [7:0] exp_p;
        exp_p = 8'(ia * ib);
        prev  = product;
        a = ia;
        b = ib;
        start = 1'b1;
        tick();
        start = 1'b0;
        a = ~ia;
        b = ~ib;
        busy_cnt = 0;
        guard = 0;
        while (!done && guard < 20) begin
            if (busy) busy_cnt++;
            if (busy && product !== prev) chk({name, "_hold"}, product, prev);
            tick();
            guard++;
        end
        chk({name, "_done_seen"}, done, 1'b1);
        chk({name, "_busy_cycles"}, busy_cnt, 4);
        chk({name, "_product"}, product, exp_p);
        tick();
        chk({name, "_done_pulse"}, done, 1'b0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        start  = 1'b0;
        a      = 4'h0;
        b      = 4'h0;
        rst_n  = 1'b0;

        vecs[0] = '{4'd15, 4'd15, 8'hE1};
        vecs[1] = '{4'd13, 4'd11, 8'h8F};
        vecs[2] = '{4'd0,  4'd9,  8'h00};
        vecs[3] = '{4'd7,  4'd1,  8'h07};
        vecs[4] = '{4'd1,  4'd15, 8'h0F};
        vecs[5] = '{4'd8,  4'd8,  8'h40};
        vecs[6] = '{4'd15, 4'd0,  8'h00};
        vecs[7] = '{4'd10, 4'd12, 8'h78};

        #12;
        chk("rst_ready", ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_product", product, 8'h00);
        rst_n = 1'b1;
        tick();
        chk("idle_ready", ready, 1'b1);

        for (int i = 0; i < 8; i++) begin
            chk($sformatf("vec%0d_table", i), vecs[i].exp_p, 8'(vecs[i].va * vecs[i].vb));
            run_op(vecs[i].va, vecs[i].vb, $sformatf("vec%0d", i));
        end

        // start held high through RUN, operand change ignored, restart from DONE
        a = 4'd3;
        b = 4'd5;
        start = 1'b1;
        tick();
        a = 4'd9;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("held_busy%0d", i), busy, 1'b1);
            chk($sformatf("held_ready%0d", i), ready, 1'b0);
            tick();
        end
        chk("held_done", done, 1'b1);
        chk("held_product", product, 8'h0F);
        tick();
        chk("held_restart_busy", busy, 1'b1);
        chk("held_restart_done", done, 1'b0);
        start = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("held_prev_visible", product, 8'h0F);
        tick();
        chk("held2_done", done, 1'b1);
        chk("held2_product", product, 8'h2D);
        tick();

        // async reset in the second RUN cycle discards the result
        a = 4'd15;
        b = 4'd15;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("mid_busy_before", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", ready, 1'b1);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_product", product, 8'h00);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("mid_no_done%0d", i), done, 1'b0);
        end
        chk("mid_product_after", product, 8'h00);

        for (int i = 0; i < 30; i++) begin
            run_op(4'($urandom_range(15)), 4'($urandom_range(15)), $sformatf("rnd%0d", i));
        end

        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                run_op(4'(i), 4'(j), $sformatf("ex_%0d_%0d", i, j));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
